// File: rtl/sbp_lookup_pkg.sv
// ============================================================================
// Module      : sbp_lookup_pkg
// Description : Shared types and constants for the SBP trie lookup stage.
//               node_t is the node word layout at the default widths
//               (KEY_BITS=32, STAGE_ID_BITS=6, LOCATION_BITS=11). The same
//               field order, MSB first, is used at any parameterisation:
//               prefix, prefix_len, child_stage_id, child_location,
//               has_left, has_right, has_result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sbp_lookup_pkg;

  // Stage id carried by a token whose lookup has completed.
  localparam int STAGE_ID_DONE = 0;

  localparam int DFLT_KEY_BITS      = 32;
  localparam int DFLT_STAGE_ID_BITS = 6;
  localparam int DFLT_LOCATION_BITS = 11;
  localparam int DFLT_PLEN_BITS     = $clog2(DFLT_KEY_BITS + 1);

  // Width of one node word for a given parameterisation.
  function automatic int node_bits(input int key_bits, input int stage_id_bits,
                                   input int location_bits);
    return key_bits + $clog2(key_bits + 1) + stage_id_bits + location_bits + 3;
  endfunction

  typedef struct packed {
    logic [DFLT_KEY_BITS-1:0]      prefix;
    logic [DFLT_PLEN_BITS-1:0]     prefix_len;
    logic [DFLT_STAGE_ID_BITS-1:0] child_stage_id;
    logic [DFLT_LOCATION_BITS-1:0] child_location;
    logic                          has_left;
    logic                          has_right;
    logic                          has_result;
  } node_t;

endpackage

`default_nettype wire

// File: rtl/sbp_node_ram.sv
// ============================================================================
// Module      : sbp_node_ram
// Description : Simple dual-port node RAM, one write port and one read port
//               with a registered read (1-cycle latency). Contents are never
//               reset.
//               Macro SBP_LOOKUP_WR_BYPASS_EN: when defined a read of the
//               address written in the same cycle returns wr_data
//               (write-first); otherwise the old contents are returned
//               (read-first).
// Ports       : clk      - clock
//               wr_en    - write strobe
//               wr_addr  - write address
//               wr_data  - write data
//               rd_addr  - read address (sampled every cycle)
//               rd_data  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbp_node_ram #(
  parameter int ADDR_BITS = 11,
  parameter int DATA_BITS = 58
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef SBP_LOOKUP_WR_BYPASS_EN
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end
`else
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/sbp_lookup_stage_pipe.sv
// ============================================================================
// Module      : sbp_lookup_stage_pipe
// Description : One stage of a pipelined trie (longest-prefix) lookup.
//               Cycle 1: token registered while the node RAM is read at
//               location_i. Cycle 2: prefix compare, best-result update and
//               child selection, registered to the outputs. No backpressure.
//               Macro SBP_LOOKUP_WR_BYPASS_EN selects write-first RAM reads
//               (see sbp_node_ram).
// Ports       : clk, rst (synchronous, active-low)
//               valid_i/key_i/bit_pos_i/stage_id_i/location_i/result_i/
//               result_valid_i - incoming lookup token
//               valid_o/key_o/bit_pos_o/stage_id_o/location_o/result_o/
//               result_valid_o - outgoing token, 2 cycles later
//               wr_en/wr_addr/wr_data - node RAM update port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbp_lookup_stage_pipe
  import sbp_lookup_pkg::*;
#(
  parameter  int STAGE_ID      = 1,
  parameter  int STAGE_ID_BITS = 6,
  parameter  int LOCATION_BITS = 11,
  parameter  int KEY_BITS      = 32,
  localparam int PLEN_BITS     = $clog2(KEY_BITS + 1),
  localparam int RES_BITS      = STAGE_ID_BITS + LOCATION_BITS,
  localparam int NODE_BITS     = node_bits(KEY_BITS, STAGE_ID_BITS, LOCATION_BITS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [KEY_BITS-1:0]      key_i,
  input  logic [PLEN_BITS-1:0]     bit_pos_i,
  input  logic [STAGE_ID_BITS-1:0] stage_id_i,
  input  logic [LOCATION_BITS-1:0] location_i,
  input  logic [RES_BITS-1:0]      result_i,
  input  logic                     result_valid_i,
  output logic                     valid_o,
  output logic [KEY_BITS-1:0]      key_o,
  output logic [PLEN_BITS-1:0]     bit_pos_o,
  output logic [STAGE_ID_BITS-1:0] stage_id_o,
  output logic [LOCATION_BITS-1:0] location_o,
  output logic [RES_BITS-1:0]      result_o,
  output logic                     result_valid_o,
  input  logic                     wr_en,
  input  logic [LOCATION_BITS-1:0] wr_addr,
  input  logic [NODE_BITS-1:0]     wr_data
);

  localparam logic [STAGE_ID_BITS-1:0] MY_STAGE = STAGE_ID_BITS'(STAGE_ID);
  localparam logic [STAGE_ID_BITS-1:0] DONE_ID  = STAGE_ID_BITS'(STAGE_ID_DONE);
  localparam logic [PLEN_BITS-1:0]     KEY_LEN  = PLEN_BITS'(KEY_BITS);

  // Node layout at this instance's widths; same field order as node_t.
  typedef struct packed {
    logic [KEY_BITS-1:0]      prefix;
    logic [PLEN_BITS-1:0]     prefix_len;
    logic [STAGE_ID_BITS-1:0] child_stage_id;
    logic [LOCATION_BITS-1:0] child_location;
    logic                     has_left;
    logic                     has_right;
    logic                     has_result;
  } stage_node_t;

  logic [NODE_BITS-1:0] rd_data;
  stage_node_t          node;

  sbp_node_ram #(
    .ADDR_BITS (LOCATION_BITS),
    .DATA_BITS (NODE_BITS)
  ) u_node_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (location_i),
    .rd_data (rd_data)
  );

  assign node = stage_node_t'(rd_data);

  // Stage 1: token travels alongside the RAM read.
  logic                     s1_valid;
  logic [KEY_BITS-1:0]      s1_key;
  logic [PLEN_BITS-1:0]     s1_bit_pos;
  logic [STAGE_ID_BITS-1:0] s1_stage_id;
  logic [LOCATION_BITS-1:0] s1_location;
  logic [RES_BITS-1:0]      s1_result;
  logic                     s1_result_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid        <= 1'b0;
      s1_key          <= '0;
      s1_bit_pos      <= '0;
      s1_stage_id     <= '0;
      s1_location     <= '0;
      s1_result       <= '0;
      s1_result_valid <= 1'b0;
    end else begin
      s1_valid        <= valid_i;
      s1_key          <= key_i;
      s1_bit_pos      <= bit_pos_i;
      s1_stage_id     <= stage_id_i;
      s1_location     <= location_i;
      s1_result       <= result_i;
      s1_result_valid <= result_valid_i;
    end
  end

  // Stage 2: compare and next-hop selection.
  logic                     sel;
  logic [PLEN_BITS-1:0]     plen_eff;
  logic [KEY_BITS-1:0]      prefix_mask;
  logic                     match;
  logic [KEY_BITS-1:0]      key_shifted;
  logic                     go_right;
  logic                     child_exists;
  logic [PLEN_BITS-1:0]     nxt_bit_pos;
  logic [STAGE_ID_BITS-1:0] nxt_stage_id;
  logic [LOCATION_BITS-1:0] nxt_location;
  logic [RES_BITS-1:0]      nxt_result;
  logic                     nxt_result_valid;

  always_comb begin
    sel              = s1_valid && (s1_stage_id == MY_STAGE);
    plen_eff         = (node.prefix_len > KEY_LEN) ? KEY_LEN : node.prefix_len;
    // Ones in the top plen_eff bits; all-zero mask (len 0) always matches.
    prefix_mask      = ~({KEY_BITS{1'b1}} >> plen_eff);
    match            = ((s1_key ^ node.prefix) & prefix_mask) == '0;
    // Bring the key bit at the current depth up to the MSB.
    key_shifted      = s1_key << s1_bit_pos;
    go_right         = key_shifted[KEY_BITS-1];
    child_exists     = (s1_bit_pos < KEY_LEN) &&
                       (go_right ? node.has_right : node.has_left);

    nxt_bit_pos      = '0;
    nxt_stage_id     = '0;
    nxt_location     = '0;
    nxt_result       = '0;
    nxt_result_valid = 1'b0;

    if (s1_valid) begin
      nxt_bit_pos      = s1_bit_pos;
      nxt_stage_id     = s1_stage_id;
      nxt_location     = s1_location;
      nxt_result       = s1_result;
      nxt_result_valid = s1_result_valid;
      if (sel) begin
        if (match && node.has_result) begin
          nxt_result       = {MY_STAGE, s1_location};
          nxt_result_valid = 1'b1;
        end
        if (child_exists) begin
          nxt_stage_id = node.child_stage_id;
          // Right child sits just after the left one when both exist.
          nxt_location = node.child_location +
                         LOCATION_BITS'(go_right && node.has_left);
        end else begin
          nxt_stage_id = DONE_ID;
          nxt_location = '0;
        end
        nxt_bit_pos = (s1_bit_pos >= KEY_LEN) ? KEY_LEN : s1_bit_pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o        <= 1'b0;
      key_o          <= '0;
      bit_pos_o      <= '0;
      stage_id_o     <= '0;
      location_o     <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else begin
      valid_o        <= s1_valid;
      key_o          <= s1_valid ? s1_key : '0;
      bit_pos_o      <= nxt_bit_pos;
      stage_id_o     <= nxt_stage_id;
      location_o     <= nxt_location;
      result_o       <= nxt_result;
      result_valid_o <= nxt_result_valid;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sbp_lookup_stage_pipe.sv
// ============================================================================
// Module      : tb_sbp_lookup_stage_pipe
// Description : Self-checking bench for sbp_lookup_stage_pipe (default
//               parameters). Expected tokens are queued when driven and
//               compared two cycles later. Honours SBP_LOOKUP_WR_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sbp_lookup_stage_pipe;
  import sbp_lookup_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] key;
    logic [5:0]  bit_pos;
    logic [5:0]  stage_id;
    logic [10:0] location;
    logic [16:0] result;
    logic        result_valid;
  } tok_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] key_i = '0;
  logic [5:0]  bit_pos_i = '0;
  logic [5:0]  stage_id_i = '0;
  logic [10:0] location_i = '0;
  logic [16:0] result_i = '0;
  logic        result_valid_i = 1'b0;
  logic        valid_o;
  logic [31:0] key_o;
  logic [5:0]  bit_pos_o;
  logic [5:0]  stage_id_o;
  logic [10:0] location_o;
  logic [16:0] result_o;
  logic        result_valid_o;
  logic        wr_en = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [57:0] wr_data = '0;

  always #5 clk = ~clk;

  sbp_lookup_stage_pipe dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .key_i(key_i), .bit_pos_i(bit_pos_i),
    .stage_id_i(stage_id_i), .location_i(location_i),
    .result_i(result_i), .result_valid_i(result_valid_i),
    .valid_o(valid_o), .key_o(key_o), .bit_pos_o(bit_pos_o),
    .stage_id_o(stage_id_o), .location_o(location_o),
    .result_o(result_o), .result_valid_o(result_valid_o),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int    checks = 0;
  int    errors = 0;
  tok_t  q[$];
  node_t shadow [0:2047];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one stage for one token against one node.
  function automatic tok_t model(input tok_t t, input node_t n);
    tok_t r;
    int   plen;
    int   bp;
    bit   right;
    bit   has;
    if (!t.valid) return '0;
    r = t;
    if (t.stage_id != 6'd1) return r;
    plen = (n.prefix_len > 6'd32) ? 32 : int'(n.prefix_len);
    if (n.has_result && (plen == 0 || (t.key >> (32 - plen)) == (n.prefix >> (32 - plen)))) begin
      r.result       = {6'd1, t.location};
      r.result_valid = 1'b1;
    end
    bp = int'(t.bit_pos);
    if (bp >= 32) begin
      r.stage_id = 6'd0;
      r.location = 11'd0;
      r.bit_pos  = 6'd32;
    end else begin
      right = t.key[31 - bp];
      has   = right ? n.has_right : n.has_left;
      if (has) begin
        r.stage_id = n.child_stage_id;
        r.location = 11'(n.child_location + ((right && n.has_left) ? 1 : 0));
      end else begin
        r.stage_id = 6'd0;
        r.location = 11'd0;
      end
      r.bit_pos = 6'(bp + 1);
    end
    return r;
  endfunction

  // One clock: compare the token due now, then drive the next cycle.
  task automatic step(input tok_t t, input logic rst_v, input logic we,
                      input logic [10:0] wa, input node_t wd);
    tok_t  e;
    node_t rd;
    @(negedge clk);
    if (q.size() >= 2) begin
      e = q.pop_front();
      check("valid_o", 64'(valid_o), 64'(e.valid));
      check("key_o", 64'(key_o), 64'(e.key));
      check("bit_pos_o", 64'(bit_pos_o), 64'(e.bit_pos));
      check("stage_id_o", 64'(stage_id_o), 64'(e.stage_id));
      check("location_o", 64'(location_o), 64'(e.location));
      check("result_o", 64'(result_o), 64'(e.result));
      check("result_valid_o", 64'(result_valid_o), 64'(e.result_valid));
    end
    rst            = rst_v;
    valid_i        = t.valid;
    key_i          = t.key;
    bit_pos_i      = t.bit_pos;
    stage_id_i     = t.stage_id;
    location_i     = t.location;
    result_i       = t.result;
    result_valid_i = t.result_valid;
    wr_en          = we;
    wr_addr        = wa;
    wr_data        = wd;
    rd = shadow[t.location];
`ifdef SBP_LOOKUP_WR_BYPASS_EN
    if (we && wa == t.location) rd = wd;
`endif
    if (!rst_v) begin
      foreach (q[i]) q[i] = '0;
      e = '0;
    end else begin
      e = model(t, rd);
    end
    q.push_back(e);
    if (we) shadow[wa] = wd;
  endtask

  function automatic tok_t mk(input logic [31:0] key, input logic [5:0] bp,
                              input logic [5:0] sid, input logic [10:0] loc,
                              input logic [16:0] res, input logic rv);
    tok_t t;
    t.valid = 1'b1; t.key = key; t.bit_pos = bp; t.stage_id = sid;
    t.location = loc; t.result = res; t.result_valid = rv;
    return t;
  endfunction

  function automatic node_t mkn(input logic [31:0] pfx, input logic [5:0] plen,
                                input logic [5:0] cs, input logic [10:0] cl,
                                input logic hl, input logic hr, input logic hres);
    node_t n;
    n.prefix = pfx; n.prefix_len = plen; n.child_stage_id = cs;
    n.child_location = cl; n.has_left = hl; n.has_right = hr; n.has_result = hres;
    return n;
  endfunction

  initial begin
    tok_t  idle;
    node_t n5, n6, n7, n5b, n9;
    idle = '0;
    n5   = mkn(32'h0A000000, 6'd8, 6'd3, 11'd10, 1'b1, 1'b1, 1'b1);
    n6   = mkn(32'h12345678, 6'd0, 6'd4, 11'd20, 1'b0, 1'b1, 1'b1);
    n7   = mkn(32'hC0A80101, 6'd40, 6'd2, 11'd2047, 1'b1, 1'b0, 1'b1);
    n5b  = mkn(32'hFF000000, 6'd4, 6'd9, 11'd100, 1'b1, 1'b1, 1'b0);
    n9   = mkn(32'h80000000, 6'd1, 6'd5, 11'd2047, 1'b1, 1'b1, 1'b1);

    // Reset with valid tokens present; RAM writes honoured during reset.
    step(mk(32'h0A800000, 6'd8, 6'd1, 11'd5, 17'd0, 1'b0), 1'b0, 1'b1, 11'd5, n5);
    step(mk(32'h0A800000, 6'd8, 6'd1, 11'd5, 17'd0, 1'b0), 1'b0, 1'b1, 11'd6, n6);
    step(idle, 1'b1, 1'b1, 11'd7, n7);

    // Match with result; right child after left.
    step(mk(32'h0A800000, 6'd8, 6'd1, 11'd5, 17'h00abc, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    // Mismatch, left child.
    step(mk(32'h0B000000, 6'd8, 6'd1, 11'd5, 17'h01234, 1'b1), 1'b1, 1'b0, 11'd0, n5);
    // Zero-length prefix: left absent -> finished; right present.
    step(mk(32'h00000000, 6'd0, 6'd1, 11'd6, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'hFFFFFFFF, 6'd5, 6'd1, 11'd6, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    // Depth at / past key width: no child, bit_pos saturates.
    step(mk(32'hFFFFFFFF, 6'd32, 6'd1, 11'd6, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'h00000001, 6'd40, 6'd1, 11'd5, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'h0A000000, 6'd31, 6'd1, 11'd5, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    // Oversized prefix_len clamps to full key.
    step(mk(32'hC0A80101, 6'd0, 6'd1, 11'd7, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'hC0A80100, 6'd0, 6'd1, 11'd7, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    // Unselected tokens pass unchanged, back-to-back.
    step(mk(32'hDEADBEEF, 6'd3, 6'd2, 11'd5, 17'h1ffff, 1'b1), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'h01020304, 6'd9, 6'd0, 11'd0, 17'h00001, 1'b1), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'hCAFEF00D, 6'd40, 6'd2, 11'd1234, 17'h0beef, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'h0A800000, 6'd8, 6'd63, 11'd5, 17'h00002, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(idle, 1'b1, 1'b0, 11'd0, n5);

    // Random traffic over the initialised nodes, some bubbles.
    for (int i = 0; i < 40; i++) begin
      tok_t t;
      t = mk($urandom, 6'($urandom_range(0, 35)), 6'($urandom_range(0, 2)),
             11'($urandom_range(5, 7)), 17'($urandom), 1'($urandom));
      t.valid = ($urandom_range(0, 4) != 0);
      step(t, 1'b1, 1'b0, 11'd0, n5);
    end

    // Write and lookup of the same node in the same cycle.
    step(mk(32'hF0800000, 6'd8, 6'd1, 11'd5, 17'd0, 1'b0), 1'b1, 1'b1, 11'd5, n5b);
    step(mk(32'hF0800000, 6'd8, 6'd1, 11'd5, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'h0A800000, 6'd8, 6'd1, 11'd5, 17'd0, 1'b0), 1'b1, 1'b1, 11'd5, n5);

    // Reset with two tokens in flight; write during reset.
    step(mk(32'h0A800000, 6'd8, 6'd1, 11'd5, 17'd7, 1'b1), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'h0B000000, 6'd8, 6'd1, 11'd5, 17'd8, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'hFFFFFFFF, 6'd0, 6'd1, 11'd6, 17'd9, 1'b0), 1'b0, 1'b1, 11'd9, n9);
    step(mk(32'h0A800000, 6'd8, 6'd1, 11'd5, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'hFFFFFFFF, 6'd5, 6'd1, 11'd6, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);
    step(mk(32'hC0000000, 6'd1, 6'd1, 11'd9, 17'd0, 1'b0), 1'b1, 1'b0, 11'd0, n5);

    for (int i = 0; i < 3; i++) step(idle, 1'b1, 1'b0, 11'd0, n5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
